// File: rtl/embedded_io_bank_ctrl_if.sv
// Pad-bank signal bundle between the eFPGA fabric/pad environment (master)
// and the embedded IO bank controller (slave).
interface embedded_io_bank_ctrl_if #(
  parameter int NUM_IO = 8
);
  logic [NUM_IO-1:0] fpga_out;
  logic [NUM_IO-1:0] fpga_dir;
  logic [NUM_IO-1:0] soc_in;
  logic [NUM_IO-1:0] soc_out;
  logic [NUM_IO-1:0] soc_dir;
  logic [NUM_IO-1:0] fpga_in;
  logic [NUM_IO-1:0] turn_busy;

  modport master (
    output fpga_out, fpga_dir, soc_in,
    input  soc_out, soc_dir, fpga_in, turn_busy
  );

  modport slave (
    input  fpga_out, fpga_dir, soc_in,
    output soc_out, soc_dir, fpga_in, turn_busy
  );
endinterface

// File: rtl/embedded_io_bank_ctrl.sv
// Embedded IO bank sequencer: isolation until configured, hi-Z turnaround per pad.
// Optional macro EMBEDDED_IO_LOOPBACK_EN adds lb_en (fabric out -> fabric in loopback).
//
// bank state | meaning
// B_ISOLATE  | pads isolated, waiting for cfg_done=1 and iso_req=0
// B_SETTLE   | TURN_CYCLES-long quiet window before the pads go live
// B_ACTIVE   | pad FSMs running
//
// pad state  | meaning
// P_IN       | SoC drives the pad, fabric sees synchronised soc_in
// P_TURN     | hi-Z window, nobody drives
// P_OUT      | fabric drives the pad
module embedded_io_bank_ctrl #(
  parameter int NUM_IO      = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_done,
  input  logic iso_req,
`ifdef EMBEDDED_IO_LOOPBACK_EN
  input  logic lb_en,
`endif
  output logic bank_active,
  embedded_io_bank_ctrl_if.slave pads
);

  localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = (TURN_CYCLES > 0) ? CW'(TURN_CYCLES - 1) : '0;

  typedef enum logic [1:0] {B_ISOLATE, B_SETTLE, B_ACTIVE} bank_state_t;
  typedef enum logic [1:0] {P_IN, P_TURN, P_OUT} pad_state_t;

  bank_state_t       bank_st;
  logic [CW-1:0]     settle_cnt;
  pad_state_t        pad_st  [NUM_IO];
  pad_state_t        pad_nxt [NUM_IO];
  logic [CW-1:0]     pad_cnt [NUM_IO];
  logic [CW-1:0]     cnt_nxt [NUM_IO];
  logic [NUM_IO-1:0] pad_tgt;
  logic [NUM_IO-1:0] tgt_nxt;
  logic [NUM_IO-1:0] sync_q  [SYNC_STAGES-1];

  logic              leave;
  logic              stay_active;
  logic              active_nxt;
  logic [NUM_IO-1:0] dir_d;
  logic [NUM_IO-1:0] out_d;
  logic [NUM_IO-1:0] busy_d;
  logic [NUM_IO-1:0] in_d;

  // iso_req or a lost configuration both drop the bank on the next edge.
  assign leave       = iso_req | ~cfg_done;
  assign stay_active = (bank_st == B_ACTIVE) & ~leave;
  assign active_nxt  = stay_active | ((bank_st == B_SETTLE) & ~leave & (settle_cnt == '0));

  // pad_tgt=1 means the running turnaround heads toward P_OUT.
  always_comb begin
    tgt_nxt = pad_tgt;
    dir_d   = '0;
    busy_d  = '0;
    in_d    = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      pad_nxt[i] = pad_st[i];
      cnt_nxt[i] = pad_cnt[i];
      if (!stay_active) begin
        pad_nxt[i] = P_IN;
        cnt_nxt[i] = '0;
        tgt_nxt[i] = 1'b0;
      end else begin
        case (pad_st[i])
          P_IN: if (pads.fpga_dir[i]) begin
            if (TURN_CYCLES == 0) pad_nxt[i] = P_OUT;
            else begin
              pad_nxt[i] = P_TURN;
              tgt_nxt[i] = 1'b1;
              cnt_nxt[i] = RELOAD;
            end
          end
          P_OUT: if (!pads.fpga_dir[i]) begin
            if (TURN_CYCLES == 0) pad_nxt[i] = P_IN;
            else begin
              pad_nxt[i] = P_TURN;
              tgt_nxt[i] = 1'b0;
              cnt_nxt[i] = RELOAD;
            end
          end
          P_TURN: begin
            // a request change restarts the full window toward the new target
            if (pads.fpga_dir[i] != pad_tgt[i]) begin
              tgt_nxt[i] = pads.fpga_dir[i];
              cnt_nxt[i] = RELOAD;
            end else if (pad_cnt[i] == '0) begin
              pad_nxt[i] = pad_tgt[i] ? P_OUT : P_IN;
            end else begin
              cnt_nxt[i] = pad_cnt[i] - CW'(1);
            end
          end
          default: pad_nxt[i] = P_IN;
        endcase
      end
      dir_d[i]  = active_nxt && pad_nxt[i] == P_OUT;
      busy_d[i] = active_nxt && pad_nxt[i] == P_TURN;
      in_d[i]   = active_nxt && pad_nxt[i] == P_IN && sync_q[SYNC_STAGES-2][i];
    end
`ifdef EMBEDDED_IO_LOOPBACK_EN
    if (lb_en && active_nxt) begin
      dir_d = '0;
      in_d  = pads.fpga_out;
    end
`endif
    out_d = dir_d & pads.fpga_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st         <= B_ISOLATE;
      settle_cnt      <= '0;
      bank_active     <= 1'b0;
      pad_tgt         <= '0;
      pads.soc_dir    <= '0;
      pads.soc_out    <= '0;
      pads.fpga_in    <= '0;
      pads.turn_busy  <= '0;
      for (int i = 0; i < NUM_IO; i++) begin
        pad_st[i]  <= P_IN;
        pad_cnt[i] <= '0;
      end
    end else begin
      case (bank_st)
        B_ISOLATE: if (cfg_done && !iso_req) begin
          bank_st    <= B_SETTLE;
          settle_cnt <= RELOAD;
        end
        B_SETTLE: begin
          if (leave)                  bank_st <= B_ISOLATE;
          else if (settle_cnt == '0) bank_st <= B_ACTIVE;
          else                        settle_cnt <= settle_cnt - CW'(1);
        end
        B_ACTIVE: if (leave) bank_st <= B_ISOLATE;
        default:  bank_st <= B_ISOLATE;
      endcase
      bank_active    <= active_nxt;
      pad_tgt        <= tgt_nxt;
      pads.soc_dir   <= dir_d;
      pads.soc_out   <= out_d;
      pads.fpga_in   <= in_d;
      pads.turn_busy <= busy_d;
      for (int i = 0; i < NUM_IO; i++) begin
        pad_st[i]  <= pad_nxt[i];
        pad_cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // The gated fpga_in register is the last synchroniser stage, so only
  // SYNC_STAGES-1 free-running flops precede it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES - 1; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pads.soc_in;
      for (int s = 1; s < SYNC_STAGES - 1; s++) sync_q[s] <= sync_q[s-1];
    end
  end

endmodule

// File: tb/tb_embedded_io_bank_ctrl.sv
// Directed self-checking bench for embedded_io_bank_ctrl (default build, TURN_CYCLES=2).
module tb_embedded_io_bank_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic cfg_done;
  logic iso_req;
  logic bank_active;
  int   n_tests = 0;
  int   n_fail  = 0;

  embedded_io_bank_ctrl_if #(.NUM_IO(8)) pads ();

  embedded_io_bank_ctrl #(.NUM_IO(8), .TURN_CYCLES(2), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_done    (cfg_done),
    .iso_req     (iso_req),
    .bank_active (bank_active),
    .pads        (pads)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pads(input string tag, input logic [7:0] dir, input logic [7:0] sout,
                            input logic [7:0] fin, input logic [7:0] busy);
    check_eq({tag, ".soc_dir"},   pads.soc_dir,   dir);
    check_eq({tag, ".soc_out"},   pads.soc_out,   sout);
    check_eq({tag, ".fpga_in"},   pads.fpga_in,   fin);
    check_eq({tag, ".turn_busy"}, pads.turn_busy, busy);
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_done      = 1'b0;
    iso_req       = 1'b0;
    pads.fpga_out = 8'h00;
    pads.fpga_dir = 8'h00;
    pads.soc_in   = 8'hA5;
    #2;
    check_pads("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    check_eq("reset.active", 8'(bank_active), 8'h00);
    #10 rst_n = 1'b1;

    tick(4);
    check_eq("iso.active", 8'(bank_active), 8'h00);
    check_pads("iso", 8'h00, 8'h00, 8'h00, 8'h00);

    // configuration done: two SETTLE cycles before ACTIVE
    cfg_done = 1'b1;
    tick(1); check_eq("settle1.active", 8'(bank_active), 8'h00);
    tick(1); check_eq("settle2.active", 8'(bank_active), 8'h00);
    check_eq("settle2.soc_dir", pads.soc_dir, 8'h00);
    tick(1); check_eq("active.active", 8'(bank_active), 8'h01);
    check_pads("active", 8'h00, 8'h00, 8'hA5, 8'h00);

    // synchroniser latency of two edges
    pads.soc_in = 8'h5A;
    tick(1); check_eq("sync1.fpga_in", pads.fpga_in, 8'hA5);
    tick(1); check_eq("sync2.fpga_in", pads.fpga_in, 8'h5A);
    pads.soc_in = 8'hA5;
    tick(2); check_eq("sync3.fpga_in", pads.fpga_in, 8'hA5);

    // pad 0 IN -> TURN -> TURN -> OUT
    pads.fpga_dir = 8'h01;
    pads.fpga_out = 8'h01;
    tick(1); check_pads("p0.t1", 8'h00, 8'h00, 8'hA4, 8'h01);
    tick(1); check_pads("p0.t2", 8'h00, 8'h00, 8'hA4, 8'h01);
    tick(1); check_pads("p0.out", 8'h01, 8'h01, 8'hA4, 8'h00);
    pads.fpga_out = 8'h00;
    check_eq("p0.out_hold", pads.soc_out, 8'h01);
    tick(1); check_eq("p0.out_lag", pads.soc_out, 8'h00);

    // pad 3 aborts its turnaround after one cycle; window restarts
    pads.fpga_dir = 8'h09;
    tick(1); check_pads("p3.t1", 8'h01, 8'h00, 8'hA4, 8'h08);
    pads.fpga_dir = 8'h01;
    tick(1); check_pads("p3.reload", 8'h01, 8'h00, 8'hA4, 8'h08);
    tick(1); check_pads("p3.t3", 8'h01, 8'h00, 8'hA4, 8'h08);
    tick(1); check_pads("p3.in", 8'h01, 8'h00, 8'hA4, 8'h00);

    // all pads to OUT simultaneously (pad 0 already OUT)
    pads.fpga_dir = 8'hFF;
    pads.fpga_out = 8'h3C;
    tick(1); check_pads("all.t1", 8'h01, 8'h00, 8'h00, 8'hFE);
    tick(1); check_pads("all.t2", 8'h01, 8'h00, 8'h00, 8'hFE);
    tick(1); check_pads("all.out", 8'hFF, 8'h3C, 8'h00, 8'h00);

    // isolation request and re-entry through SETTLE
    iso_req = 1'b1;
    tick(1); check_pads("isoreq", 8'h00, 8'h00, 8'h00, 8'h00);
    check_eq("isoreq.active", 8'(bank_active), 8'h00);
    iso_req = 1'b0;
    tick(1); check_eq("resettle1.active", 8'(bank_active), 8'h00);
    tick(1); check_eq("resettle2.active", 8'(bank_active), 8'h00);
    tick(1); check_eq("reactive.active", 8'(bank_active), 8'h01);
    check_pads("reactive", 8'h00, 8'h00, 8'hA5, 8'h00);
    tick(1); check_pads("reactive.t1", 8'h00, 8'h00, 8'h00, 8'hFF);
    tick(2); check_pads("reactive.out", 8'hFF, 8'h3C, 8'h00, 8'h00);

    // asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #2;
    check_pads("async_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    check_eq("async_rst.active", 8'(bank_active), 8'h00);
    rst_n = 1'b1;
    tick(1); check_eq("post_rst.active", 8'(bank_active), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
